// File: rtl/tpp_bank_responder.sv
// tpp_bank_responder: rotating polyvec bank store with registered read-first access and bulk zero-fill
module tpp_bank_responder #(
    parameter int NUM_PV   = 3,
    parameter int NUM_BANK = 8,
    parameter int AW       = 9,
    parameter int DW       = 35
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PV*NUM_BANK-1:0]    tppWrEnPacked,
    input  logic [NUM_PV*NUM_BANK*AW-1:0] tppWrAddrPacked,
    input  logic [NUM_PV*NUM_BANK*DW-1:0] tppWrDataPacked,
    input  logic [NUM_PV*NUM_BANK*AW-1:0] tppRdAddrPacked,
    output logic [NUM_PV*NUM_BANK*DW-1:0] tppRdDataPacked,
    input  logic                          io_i_pre_switch,
    input  logic                          io_i_clear,
    output logic                          io_o_clear_busy,
    output logic                          io_o_clear_done,
    output logic [1:0]                    io_o_rotation,
    output logic [15:0]                   io_o_collisions
);
    localparam int NL    = NUM_PV * NUM_BANK;
    localparam int DEPTH = 1 << AW;
    localparam int IW    = $clog2(NL);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [1:0]        rot_q, rot_d;
    logic [15:0]       coll_q, coll_d;
    logic [NL*DW-1:0]  rd_q, rd_d;
    logic [DW-1:0]     mem [NL][DEPTH];
    logic [NL-1:0]     bank_we;
    logic [AW-1:0]     bank_wa [NL];
    logic [DW-1:0]     bank_wd [NL];
    logic              ext_ok, hit, clearing;
    logic [IW-1:0]     p;

    function automatic logic [IW-1:0] phys(input int k, input logic [1:0] r);
        int pv;
        pv = k / NUM_BANK + int'(r);
        if (pv >= NUM_PV) pv -= NUM_PV;
        return IW'(pv * NUM_BANK + k % NUM_BANK);
    endfunction

    assign clearing = (state_q == CLEAR);

    // Clear sequencer: walk ptr across every address, then flag completion for one cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (io_i_clear) begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
            CLEAR: begin
                state_d = &ptr_q ? DONE : CLEAR;
                ptr_d   = &ptr_q ? ptr_q : ptr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Route each logical lane to its physical bank; clear overrides all bank writes
    always_comb begin
        ext_ok  = (state_q == DONE) || (state_q == IDLE && !io_i_clear);
        hit     = 1'b0;
        rd_d    = '0;
        bank_we = '0;
        p       = '0;
        for (int b = 0; b < NL; b++) begin
            bank_wa[b] = ptr_q;
            bank_wd[b] = '0;
        end
        for (int k = 0; k < NL; k++) begin
            p = phys(k, rot_q);
            rd_d[k*DW +: DW] = clearing ? '0 : mem[p][tppRdAddrPacked[k*AW +: AW]];
            bank_we[p] = clearing || (ext_ok && tppWrEnPacked[k]);
            bank_wa[p] = clearing ? ptr_q : tppWrAddrPacked[k*AW +: AW];
            bank_wd[p] = clearing ? '0 : tppWrDataPacked[k*DW +: DW];
            hit = hit || (ext_ok && tppWrEnPacked[k] &&
                          tppWrAddrPacked[k*AW +: AW] == tppRdAddrPacked[k*AW +: AW]);
        end
        rot_d  = io_i_pre_switch ? (rot_q == 2'(NUM_PV - 1) ? 2'd0 : rot_q + 2'd1) : rot_q;
        coll_d = (hit && !(&coll_q)) ? coll_q + 16'd1 : coll_q;
    end

    // Control and read-data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rot_q   <= '0;
            coll_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rot_q   <= rot_d;
            coll_q  <= coll_d;
            rd_q    <= rd_d;
        end
    end

    // Bank storage is never reset; the reset cycle simply suppresses writes
    always_ff @(posedge clock) begin
        for (int b = 0; b < NL; b++)
            if (!reset && bank_we[b]) mem[b][bank_wa[b]] <= bank_wd[b];
    end

    assign tppRdDataPacked = clearing ? '0 : rd_q;
    assign io_o_clear_busy = clearing;
    assign io_o_clear_done = (state_q == DONE);
    assign io_o_rotation   = rot_q;
    assign io_o_collisions = coll_q;
endmodule

// File: tb/tb_tpp_bank_responder.sv
// tb_tpp_bank_responder: directed table plus randomized traffic against a behavioural bank model
module tb_tpp_bank_responder;
    localparam int NL = 24;
    localparam int AW = 9;
    localparam int DW = 35;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, pre, clr, busy, done;
    logic [NL-1:0]     we;
    logic [NL*AW-1:0]  wa, ra;
    logic [NL*DW-1:0]  wd, rd;
    logic [1:0]        rot;
    logic [15:0]       coll;

    tpp_bank_responder dut (
        .clock(clock), .reset(reset),
        .tppWrEnPacked(we), .tppWrAddrPacked(wa), .tppWrDataPacked(wd),
        .tppRdAddrPacked(ra), .tppRdDataPacked(rd),
        .io_i_pre_switch(pre), .io_i_clear(clr),
        .io_o_clear_busy(busy), .io_o_clear_done(done),
        .io_o_rotation(rot), .io_o_collisions(coll)
    );

    typedef struct {
        int          lane;
        bit          w;
        logic [8:0]  a;
        logic [34:0] d;
        logic [8:0]  r;
        bit          p;
        logic [34:0] er;
        logic [15:0] ec;
        logic [1:0]  erot;
    } vec_t;

    vec_t tbl [9];
    int checks = 0, errors = 0;
    bit chk = 1'b1;

    logic [DW-1:0]    mm [NL][512];
    int               m_rot = 0, m_cidx = -1, m_coll = 0;
    logic [NL*DW-1:0] m_reg = '0;

    task automatic check(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; ra = '0; pre = 1'b0; clr = 1'b0;
    endtask

    // Advance the model by one cycle from the spec rules, clock the DUT, then compare
    task automatic step();
        logic [NL*DW-1:0] samp;
        bit               in_clr, ok, hit;
        logic [4:0]       ph;
        if (reset) begin
            m_rot = 0; m_cidx = -1; m_coll = 0; m_reg = '0;
        end else begin
            in_clr = m_cidx >= 0 && m_cidx < 512;
            ok     = m_cidx == 512 || (m_cidx == -1 && !clr);
            hit    = 1'b0;
            samp   = '0;
            for (int k = 0; k < NL; k++) begin
                ph = 5'(((k / 8 + m_rot) % 3) * 8 + k % 8);
                if (!in_clr) samp[k*DW +: DW] = mm[ph][ra[k*AW +: AW]];
                if (ok && we[k] && wa[k*AW +: AW] == ra[k*AW +: AW]) hit = 1'b1;
            end
            for (int k = 0; k < NL; k++) begin
                ph = 5'(((k / 8 + m_rot) % 3) * 8 + k % 8);
                if (ok && we[k]) mm[ph][wa[k*AW +: AW]] = wd[k*DW +: DW];
            end
            if (in_clr) for (int b = 0; b < NL; b++) mm[b][9'(m_cidx)] = '0;
            if (hit && m_coll < 65535) m_coll++;
            if (pre) m_rot = (m_rot + 1) % 3;
            m_cidx = (m_cidx == -1) ? (clr ? 0 : -1) : (m_cidx == 512 ? -1 : m_cidx + 1);
            m_reg  = samp;
        end
        @(posedge clock);
        #1;
        if (chk) begin
            in_clr = m_cidx >= 0 && m_cidx < 512;
            check("rd_data", rd, in_clr ? '0 : m_reg);
            check("busy", busy, in_clr);
            check("done", done, m_cidx == 512);
            check("rotation", rot, m_rot);
            check("collisions", coll, m_coll);
        end
    endtask

    task automatic rand_lanes(input int amax);
        for (int k = 0; k < NL; k++) begin
            we[k] = 1'($urandom_range(0, 1));
            wa[k*AW +: AW] = 9'($urandom_range(0, amax));
            wd[k*DW +: DW] = 35'({$urandom(), $urandom()});
            ra[k*AW +: AW] = 9'($urandom_range(0, amax));
        end
    endtask

    initial begin
        logic [NL*DW-1:0] v99, v100, v200;
        int nb, done_at, nz, l;
        for (int b = 0; b < NL; b++) for (int a = 0; a < 512; a++) mm[b][a] = '0;
        tbl[0] = '{0, 1'b1, 9'd5, 35'h123456789, 9'd0, 1'b0, 35'h0,         16'd0, 2'd0};
        tbl[1] = '{0, 1'b0, 9'd0, 35'h0,         9'd5, 1'b0, 35'h123456789, 16'd0, 2'd0};
        tbl[2] = '{3, 1'b1, 9'd7, 35'hA,         9'd0, 1'b0, 35'h0,         16'd0, 2'd0};
        tbl[3] = '{3, 1'b1, 9'd7, 35'hB,         9'd7, 1'b0, 35'hA,         16'd1, 2'd0};
        tbl[4] = '{3, 1'b0, 9'd0, 35'h0,         9'd7, 1'b0, 35'hB,         16'd1, 2'd0};
        tbl[5] = '{0, 1'b1, 9'd0, 35'h11,        9'd1, 1'b0, 35'h0,         16'd1, 2'd0};
        tbl[6] = '{0, 1'b0, 9'd0, 35'h0,         9'd0, 1'b1, 35'h11,        16'd1, 2'd1};
        tbl[7] = '{8, 1'b0, 9'd0, 35'h0,         9'd0, 1'b1, 35'h0,         16'd1, 2'd2};
        tbl[8] = '{8, 1'b0, 9'd0, 35'h0,         9'd0, 1'b0, 35'h11,        16'd1, 2'd2};

        idle();
        reset = 1'b1;
        step();
        step();
        check("reset_rd", rd, '0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rot", rot, 0);
        check("reset_coll", coll, 0);
        reset = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (513) step();

        for (int i = 0; i < 9; i++) begin
            idle();
            l = tbl[i].lane;
            we[l] = tbl[i].w;
            wa[l*AW +: AW] = tbl[i].a;
            wd[l*DW +: DW] = tbl[i].d;
            ra[l*AW +: AW] = tbl[i].r;
            pre = tbl[i].p;
            step();
            check($sformatf("tbl%0d_rd", i), rd[l*DW +: DW], tbl[i].er);
            check($sformatf("tbl%0d_coll", i), coll, tbl[i].ec);
            check($sformatf("tbl%0d_rot", i), rot, tbl[i].erot);
        end

        for (int c = 0; c < 400; c++) begin
            rand_lanes(7);
            pre = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 199) == 0);
            step();
        end
        idle();
        repeat (520) step();

        for (int a = 0; a < 512; a++) begin
            we = '1;
            for (int k = 0; k < NL; k++) begin
                wa[k*AW +: AW] = 9'(a);
                wd[k*DW +: DW] = 35'({$urandom(), $urandom()}) | 35'd1;
                ra[k*AW +: AW] = 9'($urandom_range(0, 511));
            end
            step();
        end
        nb = 0; done_at = 0;
        for (int c = 1; c <= 515; c++) begin
            if (c <= 512) rand_lanes(511); else idle();
            if (c <= 512) we = '1;
            clr = (c == 1);
            step();
            if (busy) nb++;
            if (done) done_at = c;
        end
        check("clear_busy_cycles", nb, 512);
        check("clear_done_cycle", done_at, 513);
        idle();
        nz = 0;
        for (int a = 0; a < 512; a++) begin
            for (int k = 0; k < NL; k++) ra[k*AW +: AW] = 9'(a);
            step();
            if (rd != '0) nz++;
        end
        check("clear_all_zero", nz, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < NL; k++) begin
            v99[k*DW +: DW]  = 35'({$urandom(), $urandom()}) | 35'd1;
            v100[k*DW +: DW] = 35'({$urandom(), $urandom()}) | 35'd1;
            v200[k*DW +: DW] = 35'({$urandom(), $urandom()}) | 35'd1;
        end
        we = '1;
        wa = {NL{9'd99}};  wd = v99;  step();
        wa = {NL{9'd100}}; wd = v100; step();
        wa = {NL{9'd200}}; wd = v200; step();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (100) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rot", rot, 0);
        ra = {NL{9'd200}}; step(); check("abort_keep200", rd, v200);
        ra = {NL{9'd100}}; step(); check("abort_keep100", rd, v100);
        ra = {NL{9'd99}};  step(); check("abort_cleared99", rd, '0);

        idle();
        we[0] = 1'b1;
        wa[0 +: AW] = 9'd3;
        ra[0 +: AW] = 9'd3;
        for (int n = 0; n < 70000; n++) begin
            wd[0 +: DW] = 35'(n);
            chk = (n < 3) || (n >= 65530 && n < 65540) || (n > 69995);
            step();
        end
        chk = 1'b1;
        check("coll_saturated", coll, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpp_bank_responder.md
TPP_BANK_RESPONDER -- requirements
Module: tpp_bank_responder

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_PV, 3, logical polyvecs.
- NUM_BANK, 8, banks per polyvec.
- AW, 9, bank address width.
- DW, 35, bank word width.
REQ-002 clock  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 tppWrEnPacked  input  24  per-bank write enable; lane k = pv*8+bank, bit k.
REQ-005 tppWrAddrPacked  input  216  per-bank write address; lane k at [k*9 +: 9].
REQ-006 tppWrDataPacked  input  840  per-bank write data; lane k at [k*35 +: 35].
REQ-007 tppRdAddrPacked  input  216  per-bank read address; lane k at [k*9 +: 9].
REQ-008 tppRdDataPacked  output  840  per-bank registered read data; lane k at [k*35 +: 35].
REQ-009 io_i_pre_switch  input  1  single-cycle pulse; rotates the logical-to-physical polyvec map.
REQ-010 io_i_clear  input  1  single-cycle pulse; starts zero-fill of all banks.
REQ-011 io_o_clear_busy  output  1  high while zero-fill runs.
REQ-012 io_o_clear_done  output  1  one-cycle pulse when zero-fill completes.
REQ-013 io_o_rotation  output  2  current rotation value, range 0..2.
REQ-014 io_o_collisions  output  16  saturating count of same-address read/write collisions.

Function
REQ-015 Storage: 24 physical banks, each 512 x 35 bits; physical bank index = phys_pv*8+bank.
REQ-016 Mapping: logical pv p maps to phys_pv = (p + rotation) mod 3; the same map applies to write and read lanes.
REQ-017 Rotation: on an io_i_pre_switch pulse, rotation advances 0->1->2->0, taking effect from the next cycle; lane accesses issued in the pulse cycle use the old rotation.
REQ-018 Write: when lane k is enabled, mem[phys][addr] <= data at the clock edge.
REQ-019 Read: latency exactly 1 cycle; the lane-k address sampled at edge N appears on tppRdDataPacked lane k after edge N and holds until the next edge; reads occur every cycle with no enable.
REQ-020 Read-during-write, same physical bank and same address: read-first, i.e. the old data is returned.
REQ-021 Collision: in any cycle where one or more lanes have a read-first hit (REQ-020), io_o_collisions increments by 1 per cycle, not per lane, and saturates at 0xFFFF.
REQ-022 Clear FSM states:
- IDLE: on io_i_clear -> CLEAR, with ptr=0.
- CLEAR: writes zero to address ptr in all 24 banks; ptr increments; at ptr=511 -> DONE.
- DONE: io_o_clear_done=1 for one cycle -> IDLE.
REQ-023 io_o_clear_busy = (state==CLEAR); a clear takes 512 cycles of CLEAR plus 1 cycle of DONE.
REQ-024 During CLEAR:
- external writes are dropped;
- read data lanes output 0;
- io_i_clear is ignored;
- io_i_pre_switch is still honoured.
REQ-025 An io_i_clear arriving in the same cycle as an external write: the write is dropped.
REQ-026 Address ptr is 9 bits; no wrap beyond 511 within one clear.

Reset
REQ-027 Reset sets:
- rotation=0;
- state=IDLE, ptr=0;
- io_o_collisions=0;
- all tppRdDataPacked lanes=0;
- io_o_clear_busy=0, io_o_clear_done=0.
REQ-028 Reset does not alter memory contents; a reset during CLEAR aborts the fill and leaves partially cleared memory.
REQ-029 Lane inputs are ignored in the reset cycle, and no write occurs.

Verification
REQ-030 Write lane 0 addr 5 data 0x123456789, then read lane 0 addr 5 on the next cycle -> lane 0 read data = 0x123456789 one cycle after the read address is applied.
REQ-031 Preload addr 7 = 0xA on lane 3, then same-cycle write 0xB and read of lane 3 addr 7 -> reads 0xA, collisions=1; a following read -> 0xB.
REQ-032 Write 0x11 via logical pv0 bank0 addr0, pulse io_i_pre_switch twice (rotation=2), then read logical pv1 bank0 addr0 -> 0x11.
REQ-033 Fill all lanes with nonzero data, pulse io_i_clear -> busy for 512 cycles, done pulse on cycle 513, every address reads 0; writes during busy are not retained.
REQ-034 Force 70000 collision cycles -> io_o_collisions = 0xFFFF.
REQ-035 Reset asserted at ptr=100 mid-clear -> busy=0, addr 200 retains its pre-clear value, rotation=0.
